// File: rtl/rle_block_scheduler_pkg.sv
// Shared types and constants for the RLE block scheduler.
// Optional feature macro: RLE_SCHED_STATS_EN (per-component drained-block counters).
package rle_pkg;

  localparam int COEF_W_DEF = 10;
  localparam int BLK_LEN    = 64;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rle_block_scheduler_if.sv
// Stream bundle between the zig-zag buffers, the scheduler and the RLE core.
// Handshake: a beat transfers on a rising clk edge where valid && ready are both
// high; a source holding valid must keep its data stable until that transfer,
// and ready may depend combinationally on valid. core_blk_done is a 1-cycle pulse.
interface rle_block_scheduler_if #(
  parameter int COEF_W = rle_pkg::COEF_W_DEF
);
  logic              y_valid;
  logic              y_ready;
  logic [COEF_W-1:0] y_coef;
  logic              cb_valid;
  logic              cb_ready;
  logic [COEF_W-1:0] cb_coef;
  logic              cr_valid;
  logic              cr_ready;
  logic [COEF_W-1:0] cr_coef;
  logic              core_valid;
  logic              core_ready;
  logic [COEF_W-1:0] core_coef;
  logic [1:0]        core_comp;
  logic [5:0]        core_idx;
  logic              core_first;
  logic              core_last;
  logic              core_blk_done;

  // Scheduler side.
  modport master (
    input  y_valid, y_coef, cb_valid, cb_coef, cr_valid, cr_coef,
    input  core_ready, core_blk_done,
    output y_ready, cb_ready, cr_ready,
    output core_valid, core_coef, core_comp, core_idx, core_first, core_last
  );

  // Buffers / core side.
  modport slave (
    output y_valid, y_coef, cb_valid, cb_coef, cr_valid, cr_coef,
    output core_ready, core_blk_done,
    input  y_ready, cb_ready, cr_ready,
    input  core_valid, core_coef, core_comp, core_idx, core_first, core_last
  );
endinterface

// File: rtl/rle_sched_slot_ctr.sv
// MCU slot counter: slots 0..Y_BLOCKS_PER_MCU-1 are Y, then one Cb, then one Cr.
module rle_sched_slot_ctr
  import rle_pkg::*;
#(
  parameter int Y_BLOCKS_PER_MCU = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  advance,
  output comp_t comp,
  output logic  wrap
);

  localparam logic [2:0] CB_SLOT   = 3'(Y_BLOCKS_PER_MCU);
  localparam logic [2:0] LAST_SLOT = 3'(Y_BLOCKS_PER_MCU + 1);

  logic [2:0] slot;

  // Step one slot per drained block, wrapping after the Cr slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
    end else if (advance) begin
      slot <= wrap ? 3'd0 : slot + 3'd1;
    end
  end

  // Decode the current slot to a component and flag the MCU wrap.
  always_comb begin
    wrap = advance && (slot == LAST_SLOT);
    if (slot < CB_SLOT) begin
      comp = COMP_Y;
    end else if (slot == CB_SLOT) begin
      comp = COMP_CB;
    end else begin
      comp = COMP_CR;
    end
  end

endmodule

// File: rtl/rle_block_scheduler.sv
// Shares one RLE core among the Y/Cb/Cr zig-zag streams, one whole block at a
// time in MCU order, waiting for the core's end-of-block ack between blocks.
// Optional feature macro: RLE_SCHED_STATS_EN adds stat_y/cb/cr_blks counters.
module rle_block_scheduler
  import rle_pkg::*;
#(
  parameter int COEF_W           = COEF_W_DEF,
  parameter int Y_BLOCKS_PER_MCU = 4,
  parameter int DRAIN_TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  rle_block_scheduler_if.master     bus,
  output logic                      mcu_done,
  output logic                      busy,
  output logic                      err_timeout,
  output sched_state_t              dbg_state
`ifdef RLE_SCHED_STATS_EN
  ,
  output logic [15:0]               stat_y_blks,
  output logic [15:0]               stat_cb_blks,
  output logic [15:0]               stat_cr_blks
`endif
);

  localparam logic [15:0] TIMEOUT_VAL = 16'(DRAIN_TIMEOUT);
  localparam logic [5:0]  LAST_IDX    = 6'(BLK_LEN - 1);

  sched_state_t      state, state_nxt;
  comp_t             comp_q;
  comp_t             slot_comp;
  logic              slot_wrap;
  logic [5:0]        idx;
  logic [15:0]       timer;   // cycles spent in DRAIN, including the current one
  logic              sel_valid;
  logic [COEF_W-1:0] sel_coef;
  logic              xfer;
  logic              last_beat;
  logic              timeout_hit;
  logic              drain_end;

  rle_sched_slot_ctr #(
    .Y_BLOCKS_PER_MCU (Y_BLOCKS_PER_MCU)
  ) u_slot_ctr (
    .clk     (clk),
    .reset   (reset),
    .advance (drain_end),
    .comp    (slot_comp),
    .wrap    (slot_wrap)
  );

  // Select the granted upstream stream.
  always_comb begin
    sel_valid = 1'b0;
    sel_coef  = '0;
    case (comp_q)
      COMP_Y:  begin sel_valid = bus.y_valid;  sel_coef = bus.y_coef;  end
      COMP_CB: begin sel_valid = bus.cb_valid; sel_coef = bus.cb_coef; end
      default: begin sel_valid = bus.cr_valid; sel_coef = bus.cr_coef; end
    endcase
  end

  assign xfer        = (state == STREAM) && sel_valid && bus.core_ready;
  assign last_beat   = (idx == LAST_IDX);
  assign timeout_hit = (timer == TIMEOUT_VAL);
  assign drain_end   = (state == DRAIN) && (bus.core_blk_done || timeout_hit);
  assign busy        = (state != IDLE);
  assign dbg_state   = state;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the pass-through datapath; everything is quiet outside STREAM.
  always_comb begin
    state_nxt      = state;
    bus.y_ready    = 1'b0;
    bus.cb_ready   = 1'b0;
    bus.cr_ready   = 1'b0;
    bus.core_valid = 1'b0;
    bus.core_coef  = '0;
    bus.core_comp  = '0;
    bus.core_idx   = '0;
    bus.core_first = 1'b0;
    bus.core_last  = 1'b0;
    case (state)
      IDLE:   if (enable) state_nxt = GRANT;
      GRANT:  state_nxt = STREAM;
      STREAM: begin
        bus.core_valid = sel_valid;
        bus.core_coef  = sel_coef;
        bus.core_comp  = comp_q;
        bus.core_idx   = idx;
        bus.core_first = (idx == 6'd0);
        bus.core_last  = last_beat;
        case (comp_q)
          COMP_Y:  bus.y_ready  = bus.core_ready;
          COMP_CB: bus.cb_ready = bus.core_ready;
          default: bus.cr_ready = bus.core_ready;
        endcase
        if (xfer && last_beat) state_nxt = DRAIN;
      end
      DRAIN:  if (drain_end) state_nxt = enable ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Block component latch, beat index, drain timer, sticky timeout and MCU pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      comp_q      <= COMP_Y;
      idx         <= '0;
      timer       <= '0;
      err_timeout <= 1'b0;
      mcu_done    <= 1'b0;
    end else begin
      mcu_done <= slot_wrap;
      case (state)
        GRANT: begin
          comp_q <= slot_comp;
          idx    <= '0;
          timer  <= '0;
        end
        STREAM: begin
          if (xfer) begin
            idx <= idx + 6'd1;
            if (last_beat) timer <= 16'd1;
          end
        end
        DRAIN: begin
          if (!drain_end) timer <= timer + 16'd1;
          if (drain_end && !bus.core_blk_done) err_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RLE_SCHED_STATS_EN
  // Count drained blocks per component; 16-bit counters wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_y_blks  <= '0;
      stat_cb_blks <= '0;
      stat_cr_blks <= '0;
    end else if (drain_end) begin
      case (comp_q)
        COMP_Y:  stat_y_blks  <= stat_y_blks + 16'd1;
        COMP_CB: stat_cb_blks <= stat_cb_blks + 16'd1;
        default: stat_cr_blks <= stat_cr_blks + 16'd1;
      endcase
    end
  end
`endif

endmodule
